// File: rtl/pipelined_normalizer_if.sv
// pipelined_normalizer_if: input/output handshake bundle of the normalizer
interface pipelined_normalizer_if #(
    parameter int EXP_WIDTH     = 5,
    parameter int MAN_IN_WIDTH  = 15,
    parameter int MAN_OUT_WIDTH = 10
);
    logic                     in_valid;
    logic                     in_ready;
    logic [EXP_WIDTH-1:0]     exp_in;
    logic [MAN_IN_WIDTH-1:0]  man_in;
    logic                     rnd_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_WIDTH-1:0]     exp_out;
    logic [MAN_OUT_WIDTH-1:0] man_out;
    logic [2:0]               flags;
    modport master (
        output in_valid, exp_in, man_in, rnd_mode, out_ready,
        input  in_ready, out_valid, exp_out, man_out, flags
    );
    modport slave (
        input  in_valid, exp_in, man_in, rnd_mode, out_ready,
        output in_ready, out_valid, exp_out, man_out, flags
    );
endinterface

// File: rtl/pipelined_normalizer.sv
// pipelined_normalizer: two-stage float normalizer (leading-one/exponent, then shift/round/range)
module pipelined_normalizer #(
    parameter int EXP_WIDTH     = 5,
    parameter int MAN_IN_WIDTH  = 15,
    parameter int MAN_OUT_WIDTH = 10,
    parameter int INT_LEN       = 4
) (
    input logic                    clk,
    input logic                    rst,
    pipelined_normalizer_if.slave  bus
);
    localparam int FRAC_IN = MAN_IN_WIDTH - INT_LEN;
    localparam int EW2     = EXP_WIDTH + 2;
    localparam int PW      = $clog2(MAN_IN_WIDTH);
    localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_WIDTH) - 1);

    logic                     s1_valid_q;
    logic [MAN_IN_WIDTH-1:0]  s1_man_q;
    logic [PW-1:0]            s1_sh_q, sh_d, p_d;
    logic signed [EW2-1:0]    s1_e_q, e_d, e_f;
    logic                     s1_rnd_q;
    logic                     out_valid_q;
    logic [EXP_WIDTH-1:0]     exp_out_q, exp_d;
    logic [MAN_OUT_WIDTH-1:0] man_out_q, man_d, man_t, man_r;
    logic [2:0]               flags_q, flags_d;
    logic [MAN_IN_WIDTH:0]    ext;
    logic                     s1_adv, g, s, inc, carry, zero, ovf, unf;

    assign s1_adv        = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = !rst && (!s1_valid_q || s1_adv);
    assign bus.out_valid = out_valid_q;
    assign bus.exp_out   = exp_out_q;
    assign bus.man_out   = man_out_q;
    assign bus.flags     = flags_q;

    // Locate the leading one and rebias the exponent around it
    always_comb begin
        p_d = '0;
        for (int i = 0; i < MAN_IN_WIDTH; i++) if (bus.man_in[i]) p_d = PW'(i);
        sh_d = PW'(MAN_IN_WIDTH - 1) - p_d;
        e_d  = EW2'(bus.exp_in) + EW2'(p_d) - EW2'(FRAC_IN);
    end

    // Stage 1 register: holds its beat while the output stage is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_man_q   <= '0;
            s1_sh_q    <= '0;
            s1_e_q     <= '0;
            s1_rnd_q   <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid_q <= bus.in_valid;
            s1_man_q   <= bus.man_in;
            s1_sh_q    <= sh_d;
            s1_e_q     <= e_d;
            s1_rnd_q   <= bus.rnd_mode;
        end
    end

    // Align the fraction under the hidden one, round, and classify the range
    always_comb begin
        ext     = {(MAN_IN_WIDTH - 1)'(s1_man_q << s1_sh_q), 2'b00};
        man_t   = ext[MAN_IN_WIDTH -: MAN_OUT_WIDTH];
        g       = ext[MAN_IN_WIDTH - MAN_OUT_WIDTH];
        s       = |ext[MAN_IN_WIDTH - MAN_OUT_WIDTH - 1:0];
        inc     = s1_rnd_q && g && (s || man_t[0]);
        {carry, man_r} = {1'b0, man_t} + (MAN_OUT_WIDTH + 1)'(inc);
        e_f     = s1_e_q + EW2'(carry);
        zero    = ~|s1_man_q;
        ovf     = !zero && (e_f > EMAX);
        unf     = !zero && (e_f < 1);
        flags_d = {ovf, unf, zero};
        exp_d   = ovf ? '1 : (zero || unf) ? '0 : e_f[EXP_WIDTH-1:0];
        man_d   = ovf ? '1 : (zero || unf) ? '0 : man_r;
    end

    // Output register: frozen while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            exp_out_q   <= '0;
            man_out_q   <= '0;
            flags_q     <= '0;
        end else if (s1_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                exp_out_q <= exp_d;
                man_out_q <= man_d;
                flags_q   <= flags_d;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_normalizer.sv
// tb_pipelined_normalizer: directed and randomized checks against an arithmetic reference model
module tb_pipelined_normalizer;
    localparam int EW = 5, MIW = 15, MO = 10, IL = 4, FRAC = MIW - IL;

    logic clk = 0;
    logic rst = 1;
    int n_cmp = 0, n_err = 0;
    logic [17:0] exp_q[$];
    logic stall_q = 0;
    logic [18:0] held = '0;

    pipelined_normalizer_if #(.EXP_WIDTH(EW), .MAN_IN_WIDTH(MIW), .MAN_OUT_WIDTH(MO)) bus();
    pipelined_normalizer #(.EXP_WIDTH(EW), .MAN_IN_WIDTH(MIW), .MAN_OUT_WIDTH(MO), .INT_LEN(IL))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // value = 1.F * 2^(E-bias): find the leading one, scale the remainder to MO bits, round on the discarded part
    function automatic logic [17:0] model(input int e, input int m, input bit r);
        int p, ee;
        longint num, mant, rem, half;
        if (m == 0) return {3'b001, 5'd0, 10'd0};
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        ee = e + p - FRAC;
        num = longint'(m - (1 << p)) << MO;
        mant = num >> p;
        rem = num - (mant << p);
        if (r && p > 0) begin
            half = longint'(1) << (p - 1);
            if (rem > half || (rem == half && mant % 2 == 1)) mant++;
        end
        if (mant == (1 << MO)) begin
            mant = 0;
            ee++;
        end
        if (ee > (1 << EW) - 1) return {3'b100, 5'h1f, 10'h3ff};
        if (ee < 1) return {3'b010, 5'd0, 10'd0};
        return {3'b000, 5'(ee), 10'(mant)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_q = 0;
        end else begin
            if (stall_q) chk("hold", {bus.out_valid, bus.flags, bus.exp_out, bus.man_out}, held);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("extra_output", 1, 0);
                else chk("data", {bus.flags, bus.exp_out, bus.man_out}, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(int'(bus.exp_in), int'(bus.man_in), bus.rnd_mode));
            stall_q = bus.out_valid && !bus.out_ready;
            held = {bus.out_valid, bus.flags, bus.exp_out, bus.man_out};
        end
    end

    task automatic directed(input int e, input int m, input bit r, input int xe, input int xm, input int xf);
        @(posedge clk); #1;
        bus.in_valid = 1; bus.exp_in = 5'(e); bus.man_in = 15'(m); bus.rnd_mode = r; bus.out_ready = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        chk("lat1_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("lat2_valid", bus.out_valid, 1);
        chk("dir_result", {bus.flags, bus.exp_out, bus.man_out}, {3'(xf), 5'(xe), 10'(xm)});
    endtask

    task automatic send(input int e, input int m, input bit r);
        bit took;
        int n = 0;
        bus.in_valid = 1; bus.exp_in = 5'(e); bus.man_in = 15'(m); bus.rnd_mode = r;
        do begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 9) < 6);
            n++;
        end while (!took && n < 1000);
        if (!took) chk("send_timeout", 0, 1);
        bus.in_valid = 0;
    endtask

    task automatic send_rand();
        send(int'($urandom_range(0, 31)), int'($urandom_range(0, 32767) >> $urandom_range(0, 15)),
             bit'($urandom_range(0, 1)));
    endtask

    initial begin
        int n;
        bus.in_valid = 0; bus.exp_in = 0; bus.man_in = 0; bus.rnd_mode = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_outputs", {bus.flags, bus.exp_out, bus.man_out}, 0);
        chk("in_ready_after_rst", bus.in_ready, 1);
        directed(10, 15'b101010101010101, 1, 13, 10'b0101010101, 3'b000);
        directed(23, 15'b001000000000110, 1, 24, 10'b0000000010, 3'b000);
        directed(23, 15'b001000000000110, 0, 24, 10'b0000000001, 3'b000);
        directed(4, 15'h7fff, 1, 8, 0, 3'b000);
        directed(4, 15'h7fff, 0, 7, 10'h3ff, 3'b000);
        directed(31, 15'h7fff, 1, 31, 10'h3ff, 3'b100);
        directed(0, 1, 1, 0, 0, 3'b010);
        directed(17, 0, 1, 0, 0, 3'b001);
        for (int i = 0; i < 8; i++) send_rand();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                bus.out_ready = ($urandom_range(0, 9) < 6);
            end
            send_rand();
        end
        bus.out_ready = 1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
        bus.out_ready = 0;
        @(posedge clk); #1;
        bus.in_valid = 1; bus.exp_in = 5'd12; bus.man_in = 15'h1234; bus.rnd_mode = 1;
        @(posedge clk); #1;
        bus.exp_in = 5'd20; bus.man_in = 15'h0777; bus.rnd_mode = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        chk("inflight_valid", bus.out_valid, 1);
        rst = 1;
        #1;
        chk("rst_mid_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        chk("rst_flush_valid", bus.out_valid, 0);
        bus.out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale", bus.out_valid, 0);
        end
        directed(10, 15'b101010101010101, 0, 13, 10'b0101010101, 3'b000);
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_normalizer.md
PIPELINED_NORMALIZER -- requirements
Module: pipelined_normalizer

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5: biased exponent width, in and out.
REQ-002 SHALL have parameter MAN_IN_WIDTH, default 15: unnormalized mantissa input width.
REQ-003 SHALL have parameter MAN_OUT_WIDTH, default 10: fraction width out, hidden one excluded; legal range 1..MAN_IN_WIDTH-1.
REQ-004 SHALL have parameter INT_LEN, default 4: integer bits at top of man_in; FRAC_IN = MAN_IN_WIDTH-INT_LEN.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts the beat this cycle.
REQ-010 SHALL have port exp_in, input, EXP_WIDTH bits: unsigned biased exponent.
REQ-011 SHALL have port man_in, input, MAN_IN_WIDTH bits: unsigned fixed point, INT_LEN.FRAC_IN.
REQ-012 SHALL have port rnd_mode, input, 1 bit: 0 = truncate, 1 = round-nearest-even; captured per beat.
REQ-013 SHALL have port out_valid, output, 1 bit: result valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-015 SHALL have port exp_out, output, EXP_WIDTH bits: normalized exponent.
REQ-016 SHALL have port man_out, output, MAN_OUT_WIDTH bits: normalized fraction, hidden one dropped.
REQ-017 SHALL have port flags, output, 3 bits: {ovf, unf, zero}.

Function
REQ-018 SHALL transfer a beat when in_valid && in_ready, and when out_valid && out_ready.
REQ-019 SHALL be two stages: S1 = leading-one detect plus exponent adjust; S2 = shift, round, range check, output register.
REQ-020 SHALL give latency 2 cycles from accept to out_valid with no stall; throughput 1 beat/cycle.
REQ-021 SHALL stall in place: in_ready = !s1_valid || s1 advances; S1 advances when !out_valid || out_ready.
REQ-022 SHALL hold exp_out, man_out, flags stable while out_valid && !out_ready.
REQ-023 SHALL compute leading-one index p of man_in; E = exp_in + p - FRAC_IN as signed, width EXP_WIDTH+2, no wrap.
REQ-024 SHALL form F from bits below p, MSB-aligned; man_out = top MAN_OUT_WIDTH bits of F, zero-padded.
REQ-025 SHALL, when rnd_mode=1, set G = next bit of F and S = OR of the rest, and increment when G && (S || LSB).
REQ-026 SHALL make rounding carry-out set man_out to 0 and E to E+1.
REQ-027 SHALL treat man_in == 0 as zero: exp_out=0, man_out=0, flags=3'b001.
REQ-028 SHALL treat final E > 2^EXP_WIDTH-1 as overflow: exp_out all ones, man_out all ones, flags=3'b100.
REQ-029 SHALL treat final E < 1 as underflow: flush, exp_out=0, man_out=0, flags=3'b010.
REQ-030 SHALL otherwise output flags=3'b000; exp_out=0 occurs only on a zero or underflow result.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear s1_valid, out_valid, exp_out, man_out, flags to 0.
REQ-032 SHALL hold in_ready=0 during any cycle with rst high.
REQ-033 SHALL discard in-flight beats when rst is asserted mid-stream; none reappear after reset.
REQ-034 SHALL not retain rnd_mode of discarded beats.

Verification (defaults 5/15/10/4)
REQ-035 SHALL pass: exp=10, man=101010101010101, rnd=1 -> exp_out=13, man_out=0101010101, flags=000, out_valid 2 cycles later.
REQ-036 SHALL pass: exp=23, man=001000000000110 -> rnd=1: exp_out=24, man_out=0000000010; rnd=0: man_out=0000000001.
REQ-037 SHALL pass: exp=4, man=all ones, rnd=1 -> carry: exp_out=8, man_out=0; rnd=0 -> exp_out=7, man_out=all ones.
REQ-038 SHALL pass boundary cases: exp=31, man=all ones -> exp_out=11111, man_out=all ones, flags=100; exp=0, man=1 -> 0/0, flags=010; man=0 -> flags=001.
REQ-039 SHALL pass: 8 back-to-back beats with out_ready toggled randomly -> order preserved, no loss/duplication, outputs stable while stalled.
REQ-040 SHALL pass: rst asserted with 2 beats in flight -> out_valid=0 next cycle, no stale output after reset release.
